pll_reconfig_ctrl: RTL and testbench

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

---
 rtl/pll_reconfig_if.sv | 22 ++
 rtl/pll_reconfig_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reconfig_if.sv
// Request/status bundle between a host and the PLL reconfiguration controller.
// The master issues divider requests; the slave reports sequence progress.
interface pll_reconfig_if;
    logic       req;
    logic [6:0] req_mdsel;
    logic [6:0] req_odsel0;
    logic [6:0] req_odsel1;
    logic       busy;
    logic       done;
    logic       err;
    logic       locked;

    modport master (
        output req, req_mdsel, req_odsel0, req_odsel1,
        input  busy, done, err, locked
    );

    modport slave (
        input  req, req_mdsel, req_odsel0, req_odsel1,
        output busy, done, err, locked
    );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer: gate outputs, pulse PLL reset with new dividers,
// wait for a stable lock (or time out), then ungate. Runs once after reset as power-up.
module pll_reconfig_ctrl #(
    parameter int         RST_CYC     = 16,
    parameter int         GATE_CYC    = 4,
    parameter int         LOCK_STABLE = 64,
    parameter int         TIMEOUT     = 65535,
    parameter logic [6:0] MDSEL_INIT  = 7'd0,
    parameter logic [6:0] ODSEL0_INIT = 7'd0,
    parameter logic [6:0] ODSEL1_INIT = 7'd0
) (
    input  logic             clk,
    input  logic             resetn,
    pll_reconfig_if.slave    ctl,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic [6:0]       pll_mdsel,
    output logic [6:0]       pll_odsel0,
    output logic [6:0]       pll_odsel1,
    output logic             pll_enclk
);

    localparam int CW = 17;
    localparam int SW = $clog2(LOCK_STABLE + 1);

    typedef enum logic [2:0] {IDLE, GATE, RST, WAIT_LOCK, UNGATE} state_t;

    typedef struct packed {
        logic [6:0] mdsel;
        logic [6:0] odsel0;
        logic [6:0] odsel1;
    } sel_t;

    localparam sel_t SEL_INIT = '{mdsel: MDSEL_INIT, odsel0: ODSEL0_INIT, odsel1: ODSEL1_INIT};

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   stable_q, stable_d;
    sel_t            pend_q, pend_d;
    sel_t            sel_q, sel_d;
    logic            pll_reset_q, pll_reset_d;
    logic            enclk_q, enclk_d;
    logic            busy_q, busy_d;
    logic            locked_q, locked_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            lk_meta, lk;

    // pll_lock comes from the PLL's own domain; only lk is used downstream.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lk_meta <= 1'b0;
            lk      <= 1'b0;
        end else begin
            lk_meta <= pll_lock;
            lk      <= lk_meta;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RST;
            cnt_q       <= CW'(RST_CYC);
            stable_q    <= '0;
            pend_q      <= SEL_INIT;
            sel_q       <= SEL_INIT;
            pll_reset_q <= 1'b1;
            enclk_q     <= 1'b0;
            busy_q      <= 1'b1;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            pend_q      <= pend_d;
            sel_q       <= sel_d;
            pll_reset_q <= pll_reset_d;
            enclk_q     <= enclk_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        stable_d    = stable_q;
        pend_d      = pend_q;
        sel_d       = sel_q;
        pll_reset_d = pll_reset_q;
        enclk_d     = enclk_q;
        busy_d      = busy_q;
        locked_d    = locked_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (locked_q && !lk) begin
                    locked_d = 1'b0;
                    enclk_d  = 1'b0;
                    err_d    = 1'b1;
                end
                if (ctl.req) begin
                    pend_d   = '{mdsel: ctl.req_mdsel, odsel0: ctl.req_odsel0, odsel1: ctl.req_odsel1};
                    busy_d   = 1'b1;
                    enclk_d  = 1'b0;
                    locked_d = 1'b0;
                    cnt_d    = CW'(GATE_CYC);
                    state_d  = GATE;
                end
            end
            GATE: begin
                if (cnt_q == CW'(1)) begin
                    // Dividers move only together with the rising PLL reset.
                    sel_d       = pend_q;
                    pll_reset_d = 1'b1;
                    cnt_d       = CW'(RST_CYC);
                    state_d     = RST;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RST: begin
                if (cnt_q == CW'(1)) begin
                    pll_reset_d = 1'b0;
                    cnt_d       = CW'(TIMEOUT);
                    stable_d    = '0;
                    state_d     = WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT_LOCK: begin
                stable_d = lk ? stable_q + SW'(1) : '0;
                // Stable lock is tested before the timeout so it wins a tie.
                if (lk && stable_q == SW'(LOCK_STABLE - 1)) begin
                    enclk_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = UNGATE;
                end else if (cnt_q == CW'(1)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            UNGATE: begin
                locked_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pll_reset  = pll_reset_q;
    assign pll_enclk  = enclk_q;
    assign pll_mdsel  = sel_q.mdsel;
    assign pll_odsel0 = sel_q.odsel0;
    assign pll_odsel1 = sel_q.odsel1;
    assign ctl.busy   = busy_q;
    assign ctl.done   = done_q;
    assign ctl.err    = err_q;
    assign ctl.locked = locked_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl: scenario tasks plus randomized lock
// waveforms, with lock/timeout outcomes predicted from the consecutive-lock rule.
module tb_pll_reconfig_ctrl;
    localparam int RST_CYC     = 4;
    localparam int GATE_CYC    = 2;
    localparam int LOCK_STABLE = 8;
    localparam int TIMEOUT     = 100;
    localparam logic [6:0]  M_INIT   = 7'd3;
    localparam logic [6:0]  O0_INIT  = 7'd5;
    localparam logic [6:0]  O1_INIT  = 7'd9;
    localparam logic [20:0] SEL_INIT = {M_INIT, O0_INIT, O1_INIT};

    logic       clk      = 1'b0;
    logic       resetn   = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic       pll_enclk;
    logic [6:0] pll_mdsel;
    logic [6:0] pll_odsel0;
    logic [6:0] pll_odsel1;

    pll_reconfig_if bus();

    pll_reconfig_ctrl #(
        .RST_CYC(RST_CYC), .GATE_CYC(GATE_CYC), .LOCK_STABLE(LOCK_STABLE), .TIMEOUT(TIMEOUT),
        .MDSEL_INIT(M_INIT), .ODSEL0_INIT(O0_INIT), .ODSEL1_INIT(O1_INIT)
    ) dut (
        .clk(clk), .resetn(resetn), .ctl(bus), .pll_lock(pll_lock), .pll_reset(pll_reset),
        .pll_mdsel(pll_mdsel), .pll_odsel0(pll_odsel0), .pll_odsel1(pll_odsel1), .pll_enclk(pll_enclk)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy_a;
        logic        enclk_a;
        int          rise_at;
        int          fall_at;
        logic [20:0] sel_pre;
        logic [20:0] sel_at;
        bit          saw_done;
        bit          saw_err;
        bit          both;
        int          k;
    } meas_t;

    int          checks   = 0;
    int          failures = 0;
    bit          pat [0:127];
    logic [20:0] cur_sel  = SEL_INIT;

    function automatic logic [20:0] sels();
        return {pll_mdsel, pll_odsel0, pll_odsel1};
    endfunction

    // pat[i] reaches the pin i+1 cycles after WAIT_LOCK entry; two sync stages
    // later it is the lock value seen on WAIT_LOCK cycle t = i+3.
    function automatic void predict(output bit ok, output int k);
        int run;
        ok  = 1'b0;
        k   = TIMEOUT;
        run = 0;
        for (int t = 1; t <= TIMEOUT; t++) begin
            if (t >= 3 && pat[t-3]) run++;
            else run = 0;
            if (run == LOCK_STABLE) begin
                ok = 1'b1;
                k  = t;
                return;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_pat(input int from_i);
        for (int i = 0; i < 128; i++) pat[i] = (i >= from_i);
    endtask

    // PLL model: lock is low whenever its reset is high.
    task automatic wait_fall(output int rise_at, output int fall_at,
                             output logic [20:0] pre, output logic [20:0] at);
        logic [20:0] prev;
        int          cyc;
        cyc     = 0;
        prev    = sels();
        pre     = prev;
        at      = prev;
        rise_at = pll_reset ? 0 : -1;
        fall_at = -1;
        while (fall_at < 0 && cyc < 200) begin
            if (pll_reset) pll_lock = 1'b0;
            tick();
            cyc++;
            if (pll_reset && rise_at < 0) begin
                rise_at = cyc;
                pre     = prev;
                at      = sels();
            end else if (!pll_reset && rise_at >= 0) begin
                fall_at = cyc;
            end
            prev = sels();
        end
    endtask

    task automatic run_lock(input bit inject, output bit saw_done, output bit saw_err,
                            output bit both, output int k);
        saw_done = 1'b0;
        saw_err  = 1'b0;
        both     = 1'b0;
        k        = -1;
        for (int i = 0; i < TIMEOUT + 8; i++) begin
            pll_lock = pat[i];
            if (inject && i == 3) begin
                bus.req        = 1'b1;
                bus.req_mdsel  = pll_mdsel ^ 7'h15;
                bus.req_odsel0 = pll_odsel0 ^ 7'h2a;
                bus.req_odsel1 = pll_odsel1 ^ 7'h41;
            end
            if (i == 4) bus.req = 1'b0;
            tick();
            if (bus.done && bus.err) both = 1'b1;
            if (bus.done) saw_done = 1'b1;
            if (bus.err) saw_err = 1'b1;
            if (saw_done || saw_err) begin
                k = i + 1;
                break;
            end
        end
        bus.req = 1'b0;
        if (saw_done) pll_lock = 1'b1;
    endtask

    task automatic do_sequence(input logic [20:0] s, input bit inject, output meas_t r);
        bus.req        = 1'b1;
        bus.req_mdsel  = s[20:14];
        bus.req_odsel0 = s[13:7];
        bus.req_odsel1 = s[6:0];
        tick();
        bus.req   = 1'b0;
        r.busy_a  = bus.busy;
        r.enclk_a = pll_enclk;
        wait_fall(r.rise_at, r.fall_at, r.sel_pre, r.sel_at);
        run_lock(inject, r.saw_done, r.saw_err, r.both, r.k);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        checks++;
        if ({pll_reset, pll_enclk, bus.busy, bus.locked, bus.done, bus.err} !== 6'b101000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 101000",
                     {pll_reset, pll_enclk, bus.busy, bus.locked, bus.done, bus.err});
        end
        checks++;
        if (sels() !== SEL_INIT) begin
            failures++;
            $display("FAIL reset_selects: got %h expected %h", sels(), SEL_INIT);
        end
    endtask

    task automatic test_power_up();
        int rise_at, fall_at, k, ek;
        logic [20:0] pre, at;
        bit sd, se, both, ed;
        fill_pat(9);
        predict(ed, ek);
        @(negedge clk);
        resetn = 1'b1;
        wait_fall(rise_at, fall_at, pre, at);
        checks++;
        if (fall_at - rise_at != RST_CYC) begin
            failures++;
            $display("FAIL powerup_reset_len: got %0d expected %0d", fall_at - rise_at, RST_CYC);
        end
        run_lock(1'b0, sd, se, both, k);
        checks++;
        if (sd !== ed || se !== !ed || k != ek || both) begin
            failures++;
            $display("FAIL powerup_done: got done=%0d err=%0d at %0d expected done=%0d at %0d", sd, se, k, ed, ek);
        end
        tick();
        checks++;
        if ({bus.done, bus.locked, bus.busy, pll_enclk, pll_reset} !== 5'b01010) begin
            failures++;
            $display("FAIL powerup_post: got %b expected 01010", {bus.done, bus.locked, bus.busy, pll_enclk, pll_reset});
        end
        checks++;
        if (sels() !== SEL_INIT) begin
            failures++;
            $display("FAIL powerup_selects: got %h expected %h", sels(), SEL_INIT);
        end
    endtask

    task automatic test_reconfig();
        meas_t r;
        logic [20:0] ns;
        bit ed;
        int ek;
        ns = {7'd55, 7'd20, 7'd4};
        fill_pat(9);
        predict(ed, ek);
        do_sequence(ns, 1'b0, r);
        checks++;
        if ({r.busy_a, r.enclk_a} !== 2'b10) begin
            failures++;
            $display("FAIL reconfig_accept: got busy/enclk %b expected 10", {r.busy_a, r.enclk_a});
        end
        checks++;
        if (r.rise_at != GATE_CYC) begin
            failures++;
            $display("FAIL reconfig_gate_lead: got %0d expected %0d", r.rise_at, GATE_CYC);
        end
        checks++;
        if (r.sel_pre !== cur_sel || r.sel_at !== ns) begin
            failures++;
            $display("FAIL reconfig_sel_edge: got %h->%h expected %h->%h", r.sel_pre, r.sel_at, cur_sel, ns);
        end
        checks++;
        if (r.fall_at - r.rise_at != RST_CYC) begin
            failures++;
            $display("FAIL reconfig_reset_len: got %0d expected %0d", r.fall_at - r.rise_at, RST_CYC);
        end
        checks++;
        if (r.saw_done !== ed || r.k != ek || r.both) begin
            failures++;
            $display("FAIL reconfig_done: got done=%0d at %0d expected done=%0d at %0d", r.saw_done, r.k, ed, ek);
        end
        tick();
        checks++;
        if ({bus.locked, bus.busy, pll_enclk} !== 3'b101 || sels() !== ns) begin
            failures++;
            $display("FAIL reconfig_post: got %b sel %h expected 101 sel %h", {bus.locked, bus.busy, pll_enclk}, sels(), ns);
        end
        cur_sel = ns;
    endtask

    task automatic test_glitchy_lock();
        meas_t r;
        bit ed;
        int ek;
        fill_pat(0);
        pat[5] = 1'b0;
        predict(ed, ek);
        do_sequence(cur_sel, 1'b0, r);
        checks++;
        if (r.saw_done !== ed || r.saw_err || r.k != ek) begin
            failures++;
            $display("FAIL glitch_done: got done=%0d at %0d expected done=%0d at %0d", r.saw_done, r.k, ed, ek);
        end
        tick();
        checks++;
        if (bus.locked !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL glitch_post: got locked=%0d done=%0d expected 1 0", bus.locked, bus.done);
        end
    endtask

    task automatic test_lock_loss();
        int  err_at, err_cnt;
        bit  relocked;
        err_at  = -1;
        err_cnt = 0;
        pll_lock = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            pll_lock = 1'b1;
            if (bus.err) begin
                err_cnt++;
                if (err_at < 0) begin
                    err_at = c;
                    checks++;
                    if ({bus.locked, pll_enclk, bus.done} !== 3'b000) begin
                        failures++;
                        $display("FAIL lockloss_outputs: got %b expected 000", {bus.locked, pll_enclk, bus.done});
                    end
                end
            end
        end
        checks++;
        if (err_at != 3) begin
            failures++;
            $display("FAIL lockloss_err_delay: got %0d expected 3", err_at);
        end
        relocked = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.locked || bus.busy || pll_enclk) relocked = 1'b1;
            if (bus.err) err_cnt++;
        end
        checks++;
        if (relocked || err_cnt != 1) begin
            failures++;
            $display("FAIL lockloss_no_relock: got relock=%0d errs=%0d expected 0 1", relocked, err_cnt);
        end
    endtask

    task automatic test_timeout();
        meas_t r;
        logic [20:0] ns;
        bit ed;
        int ek;
        ns = 21'($urandom);
        fill_pat(200);
        predict(ed, ek);
        do_sequence(ns, 1'b0, r);
        checks++;
        if (r.saw_err !== !ed || r.saw_done || r.k != ek) begin
            failures++;
            $display("FAIL timeout_err: got err=%0d at %0d expected err=%0d at %0d", r.saw_err, r.k, !ed, ek);
        end
        checks++;
        if ({bus.locked, pll_enclk, bus.busy} !== 3'b000 || sels() !== ns) begin
            failures++;
            $display("FAIL timeout_outputs: got %b sel %h expected 000 sel %h", {bus.locked, pll_enclk, bus.busy}, sels(), ns);
        end
        tick();
        cur_sel = ns;
        ns = {7'd17, 7'd33, 7'd66};
        fill_pat(12);
        predict(ed, ek);
        do_sequence(ns, 1'b0, r);
        checks++;
        if (r.saw_done !== ed || r.k != ek || r.sel_at !== ns) begin
            failures++;
            $display("FAIL timeout_retry: got done=%0d at %0d sel %h expected done=%0d at %0d sel %h",
                     r.saw_done, r.k, r.sel_at, ed, ek, ns);
        end
        tick();
        cur_sel = ns;
    endtask

    task automatic test_busy_req();
        meas_t r;
        logic [20:0] ns;
        bit ed, busy_seen, sel_moved;
        int ek;
        ns = {7'd100, 7'd1, 7'd77};
        fill_pat(4);
        predict(ed, ek);
        do_sequence(ns, 1'b1, r);
        checks++;
        if (r.saw_done !== ed || r.k != ek || sels() !== ns) begin
            failures++;
            $display("FAIL busyreq_done: got done=%0d at %0d sel %h expected done=%0d at %0d sel %h",
                     r.saw_done, r.k, sels(), ed, ek, ns);
        end
        busy_seen = 1'b0;
        sel_moved = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.busy || pll_reset) busy_seen = 1'b1;
            if (sels() !== ns) sel_moved = 1'b1;
        end
        checks++;
        if (busy_seen || sel_moved) begin
            failures++;
            $display("FAIL busyreq_ignored: got busy=%0d moved=%0d expected 0 0", busy_seen, sel_moved);
        end
        cur_sel = ns;
    endtask

    task automatic test_random();
        meas_t r;
        logic [20:0] ns;
        bit ed, noisy;
        int ek, d, mode;
        for (int it = 0; it < 10; it++) begin
            ns    = 21'($urandom);
            mode  = int'($urandom_range(0, 3));
            d     = (mode == 0) ? 200 : int'($urandom_range(0, 70));
            noisy = (mode == 1);
            for (int i = 0; i < 128; i++)
                pat[i] = (i >= d) && !(noisy && $urandom_range(0, 5) == 0);
            predict(ed, ek);
            if (ed) begin
                pat[ek-2] = 1'b1;
                pat[ek-1] = 1'b1;
            end
            do_sequence(ns, 1'b0, r);
            checks++;
            if (r.saw_done !== ed || r.saw_err !== !ed || r.k != ek || r.both) begin
                failures++;
                $display("FAIL random_outcome[%0d]: got done=%0d err=%0d at %0d expected done=%0d at %0d",
                         it, r.saw_done, r.saw_err, r.k, ed, ek);
            end
            tick();
            checks++;
            if ({bus.locked, bus.busy, pll_enclk, bus.done, bus.err} !== {ed, 1'b0, ed, 2'b00} || sels() !== ns) begin
                failures++;
                $display("FAIL random_post[%0d]: got %b sel %h expected %b sel %h", it,
                         {bus.locked, bus.busy, pll_enclk, bus.done, bus.err}, sels(), {ed, 1'b0, ed, 2'b00}, ns);
            end
            cur_sel = ns;
        end
    endtask

    task automatic test_mid_reset();
        int rise_at, fall_at, k, ek;
        logic [20:0] pre, at;
        bit sd, se, both, ed;
        bus.req        = 1'b1;
        bus.req_mdsel  = 7'd90;
        bus.req_odsel0 = 7'd91;
        bus.req_odsel1 = 7'd92;
        tick();
        bus.req = 1'b0;
        wait_fall(rise_at, fall_at, pre, at);
        repeat (5) tick();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({pll_reset, pll_enclk, bus.busy, bus.locked, bus.done, bus.err} !== 6'b101000 || sels() !== SEL_INIT) begin
            failures++;
            $display("FAIL midreset_outputs: got %b sel %h expected 101000 sel %h",
                     {pll_reset, pll_enclk, bus.busy, bus.locked, bus.done, bus.err}, sels(), SEL_INIT);
        end
        repeat (2) tick();
        fill_pat(6);
        predict(ed, ek);
        @(negedge clk);
        resetn = 1'b1;
        wait_fall(rise_at, fall_at, pre, at);
        checks++;
        if (fall_at - rise_at != RST_CYC || at !== SEL_INIT) begin
            failures++;
            $display("FAIL midreset_rerun_rst: got len %0d sel %h expected %0d sel %h", fall_at - rise_at, at, RST_CYC, SEL_INIT);
        end
        run_lock(1'b0, sd, se, both, k);
        checks++;
        if (sd !== ed || k != ek || both) begin
            failures++;
            $display("FAIL midreset_rerun_done: got done=%0d at %0d expected done=%0d at %0d", sd, k, ed, ek);
        end
        tick();
        checks++;
        if ({bus.locked, bus.busy, pll_enclk} !== 3'b101) begin
            failures++;
            $display("FAIL midreset_post: got %b expected 101", {bus.locked, bus.busy, pll_enclk});
        end
        cur_sel = SEL_INIT;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req        = 1'b0;
        bus.req_mdsel  = 7'd0;
        bus.req_odsel0 = 7'd0;
        bus.req_odsel1 = 7'd0;
        test_reset();
        test_power_up();
        test_reconfig();
        test_glitchy_lock();
        test_lock_loss();
        test_timeout();
        test_busy_req();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
